multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control_mem_wait_timer.sv | 33 +++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller and ALUControl:
// opcode values, controller state encoding, aluOp codes and mux select encodings.
package mips_ctrl_pkg;

  // Opcode field instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // aluOp codes understood by ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that talk to memory and therefore wait on the ready handshake
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main controller (master) and the datapath (slave).
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       memReady_i;
  logic       pcEn_o;
  logic       iorD_o;
  logic       memRead_o;
  logic       memWrite_o;
  logic       irWrite_o;
  logic       memToReg_o;
  logic       regDst_o;
  logic       regWrite_o;
  logic       aluSrcA_o;
  logic [1:0] aluSrcB_o;
  logic [1:0] aluOp_o;
  logic [1:0] pcSource_o;
  logic       instrDone_o;
  logic       illegal_o;
  logic       memErr_o;

  modport master (
    input  opcode_i, zero_i, memReady_i,
    output pcEn_o, iorD_o, memRead_o, memWrite_o, irWrite_o, memToReg_o,
           regDst_o, regWrite_o, aluSrcA_o, aluSrcB_o, aluOp_o, pcSource_o,
           instrDone_o, illegal_o, memErr_o
  );

  modport slave (
    output opcode_i, zero_i, memReady_i,
    input  pcEn_o, iorD_o, memRead_o, memWrite_o, irWrite_o, memToReg_o,
           regDst_o, regWrite_o, aluSrcA_o, aluSrcB_o, aluOp_o, pcSource_o,
           instrDone_o, illegal_o, memErr_o
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Bounded wait counter for memory handshakes. Counts non-ready cycles while
// enabled; flags a timeout on the cycle the count would reach WAIT_LIMIT
// without ready. WAIT_LIMIT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout
);
  localparam int unsigned CW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
  localparam bit LIMIT_ON = (WAIT_LIMIT != 0);

  logic [CW-1:0] count;

  // Timeout when this non-ready cycle is the WAIT_LIMIT-th; ready in the same cycle wins
  assign timeout = LIMIT_ON && enable && !ready && (count == LAST_WAIT);

  // Wait cycle counter; restarts after completion, abort or leaving memory states
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear || timeout) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback; outputs are a combinational decode of state
// gated by memory ready, ALU zero and reset.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned WAIT_LIMIT    = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  multicycle_control_if.master bus
);
  state_t     state;
  state_t     state_next;
  logic       ready;
  logic       in_mem;
  logic       timeout;

  logic       pc_write;
  logic       pc_write_cond;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal;
  logic       mem_err;

  assign ready  = MEM_HANDSHAKE ? bus.memReady_i : 1'b1;
  assign in_mem = is_mem_state(state);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (!in_mem || ready),
    .enable (in_mem),
    .ready  (ready),
    .timeout(timeout)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          // Abandon the fetch and retry from a clean FETCH
          mem_read   = 1'b0;
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (bus.opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
        if (ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          mem_read   = 1'b0;
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          mem_write  = 1'b0;
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held
  assign bus.pcEn_o      = rst_ni & (pc_write | (pc_write_cond & bus.zero_i));
  assign bus.iorD_o      = rst_ni & ior_d;
  assign bus.memRead_o   = rst_ni & mem_read;
  assign bus.memWrite_o  = rst_ni & mem_write;
  assign bus.irWrite_o   = rst_ni & ir_write;
  assign bus.memToReg_o  = rst_ni & mem_to_reg;
  assign bus.regDst_o    = rst_ni & reg_dst;
  assign bus.regWrite_o  = rst_ni & reg_write;
  assign bus.aluSrcA_o   = rst_ni & alu_src_a;
  assign bus.aluSrcB_o   = {2{rst_ni}} & alu_src_b;
  assign bus.aluOp_o     = {2{rst_ni}} & alu_op;
  assign bus.pcSource_o  = {2{rst_ni}} & pc_source;
  assign bus.instrDone_o = rst_ni & instr_done;
  assign bus.illegal_o   = rst_ni & illegal;
  assign bus.memErr_o    = rst_ni & mem_err;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams with random memory wait lengths, compared cycle by cycle
// against an instruction-level reference model.
module tb_multicycle_control;
  localparam int LIMIT = 4;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;

  typedef struct packed {
    logic       pc_en;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
  } outs_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_control_if bus ();

  multicycle_control #(
    .MEM_HANDSHAKE(1'b1),
    .WAIT_LIMIT   (LIMIT)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic outs_t sample();
    outs_t s;
    s = {bus.pcEn_o, bus.iorD_o, bus.memRead_o, bus.memWrite_o, bus.irWrite_o,
         bus.memToReg_o, bus.regDst_o, bus.regWrite_o, bus.aluSrcA_o, bus.aluSrcB_o,
         bus.aluOp_o, bus.pcSource_o, bus.instrDone_o, bus.illegal_o, bus.memErr_o};
    return s;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == OPC_R || op == OPC_LW || op == OPC_SW || op == OPC_BEQ ||
           op == OPC_ADDI || op == OPC_J;
  endfunction

  function automatic logic noise();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s op=%b got=%h exp=%h", tag, bus.opcode_i, got, exp);
    end
  endtask

  // One clock: apply ready, compare on the falling edge, land 1ns after next rise
  task automatic tick(input string tag, input logic rdy, input outs_t e);
    bus.memReady_i = rdy;
    @(negedge clk_i);
    check(tag, sample(), e);
    @(posedge clk_i);
    #1;
  endtask

  // A memory access that sees nwait non-ready cycles before ready; aborts at LIMIT
  task automatic mem_phase(input string tag, input bit is_fetch, input bit is_write,
                           input int nwait, output bit ok);
    outs_t e;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      e = '0;
      e.ior_d = !is_fetch;
      if (is_fetch) e.alu_src_b = 2'b01;
      if (k >= nwait) begin
        if (is_fetch) begin
          e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_en = 1'b1;
        end else if (is_write) begin
          e.mem_write = 1'b1; e.instr_done = 1'b1;
        end else begin
          e.mem_read = 1'b1;
        end
        tick(tag, 1'b1, e);
        ok = 1'b1;
        return;
      end
      if (k == LIMIT - 1) begin
        e.mem_err = 1'b1;
        tick({tag, "_timeout"}, 1'b0, e);
        return;
      end
      if (is_write) e.mem_write = 1'b1;
      else          e.mem_read  = 1'b1;
      tick({tag, "_wait"}, 1'b0, e);
    end
  endtask

  // Reference model of one whole instruction, from fetch to its last cycle
  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
    outs_t e;
    bit    ok;
    bus.opcode_i = op;
    bus.zero_i   = z;
    mem_phase("fetch", 1'b1, 1'b0, wf, ok);
    if (!ok) return;
    e = '0; e.alu_src_b = 2'b11; e.illegal = !is_legal(op);
    tick("decode", noise(), e);
    case (op)
      OPC_LW, OPC_SW: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        tick("memadr", noise(), e);
        if (op == OPC_LW) begin
          mem_phase("memrd", 1'b0, 1'b0, wm, ok);
          if (ok) begin
            e = '0; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
            tick("memwb", noise(), e);
          end
        end else begin
          mem_phase("memwr", 1'b0, 1'b1, wm, ok);
        end
      end
      OPC_R: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        tick("exec", noise(), e);
        e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        tick("rtype_wb", noise(), e);
      end
      OPC_BEQ: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
        e.pc_en = z; e.instr_done = 1'b1;
        tick("branch", noise(), e);
      end
      OPC_ADDI: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        tick("addi_ex", noise(), e);
        e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
        tick("addi_wb", noise(), e);
      end
      OPC_J: begin
        e = '0; e.pc_source = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1;
        tick("jump", noise(), e);
      end
      default: ;
    endcase
  endtask

  initial begin
    outs_t       e;
    logic [5:0]  legal_ops [6];
    logic [5:0]  op;
    int          sel;
    legal_ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J};

    // Reset held: every output low
    rst_ni = 1'b0;
    bus.opcode_i = OPC_LW; bus.zero_i = 1'b0; bus.memReady_i = 1'b1;
    @(negedge clk_i);
    check("reset_outputs", sample(), '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Directed scenarios
    run_instr(OPC_LW,   1'b0, 0, 0);   // 5-cycle load
    run_instr(OPC_R,    1'b1, 0, 0);   // 4-cycle R-type
    run_instr(OPC_BEQ,  1'b1, 0, 0);   // taken branch
    run_instr(OPC_BEQ,  1'b0, 0, 0);   // not taken
    run_instr(OPC_ADDI, 1'b0, 3, 0);   // fetch waits 3, ready at the limit cycle
    run_instr(OPC_SW,   1'b0, 0, 9);   // write stuck: timeout
    run_instr(OPC_J,    1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);  // illegal opcode
    run_instr(OPC_LW,   1'b0, 5, 0);   // fetch timeout
    run_instr(OPC_LW,   1'b0, 1, 3);

    // Reset in the middle of a load's memory read
    bus.opcode_i = OPC_LW;
    mem_phase("rst_fetch", 1'b1, 1'b0, 0, sel[0]);
    e = '0; e.alu_src_b = 2'b11;
    tick("rst_decode", 1'b0, e);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    tick("rst_memadr", 1'b0, e);
    e = '0; e.ior_d = 1'b1; e.mem_read = 1'b1;
    tick("rst_memrd", 1'b0, e);
    rst_ni = 1'b0;
    bus.memReady_i = 1'b1;
    @(negedge clk_i);
    check("reset_mid_memrd", sample(), '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run_instr(OPC_R, 1'b0, 0, 0);      // restarts from FETCH

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 6);
      if (sel == 6) op = 6'($urandom_range(0, 63));
      else          op = legal_ops[sel];
      run_instr(op, noise(),
                ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6),
                ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
